// File: rtl/gated_clock_v2_axil_pkg.sv
// Shared types and helpers for the gated-clock AXI4-Lite register file.
// Contents: AXI response codes, write FSM state enum, address-to-index
// helper and byte-strobe merge helper.
`timescale 1ns/1ps
package gated_clock_v2_axil_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        WR_IDLE    = 2'b00,
        WR_HAVE_AW = 2'b01,
        WR_HAVE_W  = 2'b10,
        WR_RESP    = 2'b11
    } wr_state_t;

    // Word index of a byte address (registers are 32-bit, word aligned).
    function automatic int unsigned reg_index(input logic [31:0] addr);
        return addr >> 2;
    endfunction

    // Replace only the bytes whose strobe bit is set.
    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val,
                                                input logic [31:0] data,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        res = old_val;
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) res[8*k +: 8] = data[8*k +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/gated_clock_v2_axil_wr_fsm.sv
// AXI4-Lite write channel controller.
// Accepts AW and W in any order (or together), latches whichever arrives
// first, and pulses commit_c for one cycle on the cycle of the final
// handshake so the register array updates on the edge entering WR_RESP.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   awaddr/awvalid/awready     write address channel
//   wdata/wstrb/wvalid/wready  write data channel
//   bvalid/bready              write response handshake
//   commit_*_c                 combinational commit strobe and payload
`timescale 1ns/1ps
module gated_clock_v2_axil_wr_fsm
    import gated_clock_v2_axil_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [ADDR_WIDTH-1:0]     awaddr,
    input  logic                      awvalid,
    output logic                      awready,
    input  logic [DATA_WIDTH-1:0]     wdata,
    input  logic [DATA_WIDTH/8-1:0]   wstrb,
    input  logic                      wvalid,
    output logic                      wready,
    output logic                      bvalid,
    input  logic                      bready,
    output logic                      commit_c,
    output logic [ADDR_WIDTH-1:0]     commit_addr_c,
    output logic [DATA_WIDTH-1:0]     commit_data_c,
    output logic [DATA_WIDTH/8-1:0]   commit_strb_c
);

    localparam int unsigned STRB_W = DATA_WIDTH / 8;

    wr_state_t               state_q, state_d;
    logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
    logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
    logic [STRB_W-1:0]       wstrb_q, wstrb_d;
    logic                    awready_q, awready_d;
    logic                    wready_q, wready_d;
    logic                    bvalid_q, bvalid_d;
    logic                    aw_hs, w_hs;

    // State and latched-payload registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= WR_IDLE;
            awaddr_q  <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            bvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            awaddr_q  <= awaddr_d;
            wdata_q   <= wdata_d;
            wstrb_q   <= wstrb_d;
            awready_q <= awready_d;
            wready_q  <= wready_d;
            bvalid_q  <= bvalid_d;
        end
    end

    // Next-state, latching and commit decode.
    always_comb begin
        state_d       = state_q;
        awaddr_d      = awaddr_q;
        wdata_d       = wdata_q;
        wstrb_d       = wstrb_q;
        commit_c      = 1'b0;
        commit_addr_c = awaddr_q;
        commit_data_c = wdata_q;
        commit_strb_c = wstrb_q;
        aw_hs         = awvalid && awready_q;
        w_hs          = wvalid && wready_q;

        case (state_q)
            WR_IDLE: begin
                if (aw_hs && w_hs) begin
                    commit_c      = 1'b1;
                    commit_addr_c = awaddr;
                    commit_data_c = wdata;
                    commit_strb_c = wstrb;
                    state_d       = WR_RESP;
                end else if (aw_hs) begin
                    awaddr_d = awaddr;
                    state_d  = WR_HAVE_AW;
                end else if (w_hs) begin
                    wdata_d = wdata;
                    wstrb_d = wstrb;
                    state_d = WR_HAVE_W;
                end
            end
            WR_HAVE_AW: begin
                if (w_hs) begin
                    commit_c      = 1'b1;
                    commit_data_c = wdata;
                    commit_strb_c = wstrb;
                    state_d       = WR_RESP;
                end
            end
            WR_HAVE_W: begin
                if (aw_hs) begin
                    commit_c      = 1'b1;
                    commit_addr_c = awaddr;
                    state_d       = WR_RESP;
                end
            end
            WR_RESP: begin
                if (bready) state_d = WR_IDLE;
            end
            default: state_d = WR_IDLE;
        endcase

        // Readies/valid follow the state being entered so they are registered.
        awready_d = (state_d == WR_IDLE) || (state_d == WR_HAVE_W);
        wready_d  = (state_d == WR_IDLE) || (state_d == WR_HAVE_AW);
        bvalid_d  = (state_d == WR_RESP);
    end

    assign awready = awready_q;
    assign wready  = wready_q;
    assign bvalid  = bvalid_q;

endmodule

// File: rtl/gated_clock_v2_axil_regs.sv
// AXI4-Lite slave register file for the gated-clock datapath.
// NUM_REGS 32-bit registers at word offsets from 0x0, all exposed on reg_out
// (register i at [32i+31:32i]). Writes go through the write FSM sub-module;
// the read path is a single registered stage that samples the pre-write
// register value.
// Optional build macro GATED_CLOCK_V2_SLVERR_EN: out-of-range accesses
// answer SLVERR instead of OKAY (reads return zero data in both builds).
// Ports: ACLK, ARESETN (async active-low), S_AXI_* AXI4-Lite slave, reg_out.
`timescale 1ns/1ps
module gated_clock_v2_axil_regs
    import gated_clock_v2_axil_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 4,
    parameter int unsigned NUM_REGS   = 4
) (
    input  logic                           ACLK,
    input  logic                           ARESETN,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_AWADDR,
    input  logic [2:0]                     S_AXI_AWPROT,
    input  logic                           S_AXI_AWVALID,
    output logic                           S_AXI_AWREADY,
    input  logic [DATA_WIDTH-1:0]          S_AXI_WDATA,
    input  logic [DATA_WIDTH/8-1:0]        S_AXI_WSTRB,
    input  logic                           S_AXI_WVALID,
    output logic                           S_AXI_WREADY,
    output logic [1:0]                     S_AXI_BRESP,
    output logic                           S_AXI_BVALID,
    input  logic                           S_AXI_BREADY,
    input  logic [ADDR_WIDTH-1:0]          S_AXI_ARADDR,
    input  logic [2:0]                     S_AXI_ARPROT,
    input  logic                           S_AXI_ARVALID,
    output logic                           S_AXI_ARREADY,
    output logic [DATA_WIDTH-1:0]          S_AXI_RDATA,
    output logic [1:0]                     S_AXI_RRESP,
    output logic                           S_AXI_RVALID,
    input  logic                           S_AXI_RREADY,
    output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out
);

`ifdef GATED_CLOCK_V2_SLVERR_EN
    localparam logic [1:0] OOR_RESP = RESP_SLVERR;
`else
    localparam logic [1:0] OOR_RESP = RESP_OKAY;
`endif

    logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
    logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];
    logic [1:0]              bresp_q, bresp_d;
    logic                    arready_q, arready_d;
    logic                    rvalid_q, rvalid_d;
    logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
    logic [1:0]              rresp_q, rresp_d;

    logic                    commit_c;
    logic [ADDR_WIDTH-1:0]   commit_addr_c;
    logic [DATA_WIDTH-1:0]   commit_data_c;
    logic [DATA_WIDTH/8-1:0] commit_strb_c;
    int unsigned             wr_idx, rd_idx;
    logic                    ar_hs;

    // Protection bits carry no meaning for this register file.
    logic unused_prot;
    assign unused_prot = ^{S_AXI_AWPROT, S_AXI_ARPROT};

    gated_clock_v2_axil_wr_fsm #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_wr_fsm (
        .clk           (ACLK),
        .rst_n         (ARESETN),
        .awaddr        (S_AXI_AWADDR),
        .awvalid       (S_AXI_AWVALID),
        .awready       (S_AXI_AWREADY),
        .wdata         (S_AXI_WDATA),
        .wstrb         (S_AXI_WSTRB),
        .wvalid        (S_AXI_WVALID),
        .wready        (S_AXI_WREADY),
        .bvalid        (S_AXI_BVALID),
        .bready        (S_AXI_BREADY),
        .commit_c      (commit_c),
        .commit_addr_c (commit_addr_c),
        .commit_data_c (commit_data_c),
        .commit_strb_c (commit_strb_c)
    );

    // Register array, write response code and read channel registers.
    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            regs_q    <= '{default: '0};
            bresp_q   <= RESP_OKAY;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rdata_q   <= '0;
            rresp_q   <= RESP_OKAY;
        end else begin
            regs_q    <= regs_d;
            bresp_q   <= bresp_d;
            arready_q <= arready_d;
            rvalid_q  <= rvalid_d;
            rdata_q   <= rdata_d;
            rresp_q   <= rresp_d;
        end
    end

    // Write commit: byte merge into the addressed register, response code.
    always_comb begin
        regs_d  = regs_q;
        bresp_d = bresp_q;
        wr_idx  = reg_index(32'(commit_addr_c));
        if (commit_c) begin
            bresp_d = OOR_RESP;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (wr_idx == i) begin
                    regs_d[i] = apply_wstrb(regs_q[i], commit_data_c, commit_strb_c);
                    bresp_d   = RESP_OKAY;
                end
            end
        end
    end

    // Read path: sample regs_q (pre-write value) on the AR handshake.
    always_comb begin
        rvalid_d = rvalid_q;
        rdata_d  = rdata_q;
        rresp_d  = rresp_q;
        rd_idx   = reg_index(32'(S_AXI_ARADDR));
        ar_hs    = S_AXI_ARVALID && arready_q;
        if (rvalid_q && S_AXI_RREADY) rvalid_d = 1'b0;
        if (ar_hs) begin
            rvalid_d = 1'b1;
            rdata_d  = '0;
            rresp_d  = OOR_RESP;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                if (rd_idx == i) begin
                    rdata_d = regs_q[i];
                    rresp_d = RESP_OKAY;
                end
            end
        end
        arready_d = !rvalid_d;
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_out
        assign reg_out[g*DATA_WIDTH +: DATA_WIDTH] = regs_q[g];
    end

    assign S_AXI_BRESP   = bresp_q;
    assign S_AXI_ARREADY = arready_q;
    assign S_AXI_RVALID  = rvalid_q;
    assign S_AXI_RDATA   = rdata_q;
    assign S_AXI_RRESP   = rresp_q;

endmodule

// File: tb/tb_gated_clock_v2_axil_regs.sv
`timescale 1ns/1ps
module tb_gated_clock_v2_axil_regs;

    localparam int unsigned AW = 5;
    localparam int unsigned NR = 4;
`ifdef GATED_CLOCK_V2_SLVERR_EN
    localparam logic [1:0] EXP_OOR = 2'b10;
`else
    localparam logic [1:0] EXP_OOR = 2'b00;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic [AW-1:0]   awaddr, araddr;
    logic [2:0]      awprot, arprot;
    logic            awvalid, awready, wvalid, wready;
    logic [31:0]     wdata, rdata;
    logic [3:0]      wstrb;
    logic [1:0]      bresp, rresp;
    logic            bvalid, bready, arvalid, arready, rvalid, rready;
    logic [NR*32-1:0] reg_out;

    always #5 clk = ~clk;

    gated_clock_v2_axil_regs #(
        .DATA_WIDTH (32),
        .ADDR_WIDTH (AW),
        .NUM_REGS   (NR)
    ) dut (
        .ACLK          (clk),
        .ARESETN       (rst_n),
        .S_AXI_AWADDR  (awaddr),
        .S_AXI_AWPROT  (awprot),
        .S_AXI_AWVALID (awvalid),
        .S_AXI_AWREADY (awready),
        .S_AXI_WDATA   (wdata),
        .S_AXI_WSTRB   (wstrb),
        .S_AXI_WVALID  (wvalid),
        .S_AXI_WREADY  (wready),
        .S_AXI_BRESP   (bresp),
        .S_AXI_BVALID  (bvalid),
        .S_AXI_BREADY  (bready),
        .S_AXI_ARADDR  (araddr),
        .S_AXI_ARPROT  (arprot),
        .S_AXI_ARVALID (arvalid),
        .S_AXI_ARREADY (arready),
        .S_AXI_RDATA   (rdata),
        .S_AXI_RRESP   (rresp),
        .S_AXI_RVALID  (rvalid),
        .S_AXI_RREADY  (rready),
        .reg_out       (reg_out)
    );

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: plain word array, byte-wise updates.
    logic [31:0] model_mem [NR];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < int'(NR); i++) model_mem[i] = 32'h0;
    endfunction

    function automatic void model_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s);
        int idx;
        idx = int'(a) / 4;
        if (idx < int'(NR)) begin
            for (int k = 0; k < 4; k++) begin
                if (s[k]) model_mem[idx][8*k +: 8] = d[8*k +: 8];
            end
        end
    endfunction

    function automatic logic [31:0] model_rdata(input logic [AW-1:0] a);
        int idx;
        idx = int'(a) / 4;
        return (idx < int'(NR)) ? model_mem[idx] : 32'h0;
    endfunction

    function automatic logic [1:0] model_resp(input logic [AW-1:0] a);
        return ((int'(a) / 4) < int'(NR)) ? 2'b00 : EXP_OOR;
    endfunction

    function automatic logic [127:0] model_regout();
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < int'(NR); i++) r[32*i +: 32] = model_mem[i];
        return r;
    endfunction

    // Starts and ends on a falling edge. Valids raised after the given delays.
    task automatic axi_write(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly, output logic [1:0] resp);
        int cyc;
        bit aw_done, w_done, aw_fire, w_fire, got_b;
        aw_done = 0; w_done = 0; cyc = 0; resp = 2'b11;
        while (!(aw_done && w_done) && cyc < 100) begin
            awaddr  = a;
            wdata   = d;
            wstrb   = s;
            awvalid = !aw_done && (cyc >= aw_dly);
            wvalid  = !w_done && (cyc >= w_dly);
            aw_fire = awvalid && awready;
            w_fire  = wvalid && wready;
            @(negedge clk);
            if (aw_fire) aw_done = 1;
            if (w_fire)  w_done  = 1;
            cyc++;
        end
        awvalid = 0;
        wvalid  = 0;
        check("wr_handshake", 128'(aw_done && w_done), 128'(1));
        bready = 1; cyc = 0; got_b = 0;
        while (!got_b && cyc < 100) begin
            if (bvalid) begin
                got_b = 1;
                resp  = bresp;
            end
            @(negedge clk);
            cyc++;
        end
        bready = 0;
        check("wr_bvalid_seen", 128'(got_b), 128'(1));
    endtask

    task automatic axi_read(input logic [AW-1:0] a, input int rr_dly,
                            output logic [31:0] d, output logic [1:0] resp);
        int cyc;
        bit done, fire, got;
        d = 32'hxxxx_xxxx; resp = 2'b11;
        arvalid = 1; araddr = a; cyc = 0; done = 0;
        while (!done && cyc < 100) begin
            fire = arready;
            @(negedge clk);
            if (fire) done = 1;
            cyc++;
        end
        arvalid = 0;
        cyc = 0; got = 0;
        while (!got && cyc < 100) begin
            rready = (cyc >= rr_dly);
            if (rvalid && rready) begin
                got  = 1;
                d    = rdata;
                resp = rresp;
            end
            @(negedge clk);
            cyc++;
        end
        rready = 0;
        check("rd_handshake", 128'(done && got), 128'(1));
    endtask

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
        logic [3:0]    strb;
        logic [31:0]   exp_rd;
        logic [1:0]    exp_resp;
    } vec_t;

    vec_t vecs [10];

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic [1:0]  rr, br;
        logic [AW-1:0] ra;
        logic [31:0]   rdat;
        logic [3:0]    rs;

        vecs[0] = '{addr: 5'h00, data: 32'h0000_0001, strb: 4'hF, exp_rd: 32'h0000_0001, exp_resp: 2'b00};
        vecs[1] = '{addr: 5'h04, data: 32'h0000_0002, strb: 4'hF, exp_rd: 32'h0000_0002, exp_resp: 2'b00};
        vecs[2] = '{addr: 5'h08, data: 32'h0000_0003, strb: 4'hF, exp_rd: 32'h0000_0003, exp_resp: 2'b00};
        vecs[3] = '{addr: 5'h0C, data: 32'h0000_0004, strb: 4'hF, exp_rd: 32'h0000_0004, exp_resp: 2'b00};
        vecs[4] = '{addr: 5'h04, data: 32'h1122_3344, strb: 4'hF, exp_rd: 32'h1122_3344, exp_resp: 2'b00};
        vecs[5] = '{addr: 5'h04, data: 32'hAABB_CCDD, strb: 4'h5, exp_rd: 32'h11BB_33DD, exp_resp: 2'b00};
        vecs[6] = '{addr: 5'h08, data: 32'hFFFF_FFFF, strb: 4'h0, exp_rd: 32'h0000_0003, exp_resp: 2'b00};
        vecs[7] = '{addr: 5'h10, data: 32'hDEAD_BEEF, strb: 4'hF, exp_rd: 32'h0000_0000, exp_resp: EXP_OOR};
        vecs[8] = '{addr: 5'h1C, data: 32'hCAFE_F00D, strb: 4'hF, exp_rd: 32'h0000_0000, exp_resp: EXP_OOR};
        vecs[9] = '{addr: 5'h00, data: 32'h7F00_0000, strb: 4'h8, exp_rd: 32'h7F00_0001, exp_resp: 2'b00};

        rst_n = 0; awaddr = '0; araddr = '0; awprot = 3'd0; arprot = 3'd0;
        awvalid = 0; wvalid = 0; wdata = '0; wstrb = '0; bready = 0; arvalid = 0; rready = 0;
        model_reset();

        // Reset state
        @(negedge clk); @(negedge clk);
        check("rst_readys", 128'({awready, wready, arready}), 128'(0));
        check("rst_valids", 128'({bvalid, rvalid}), 128'(0));
        check("rst_resp_data", 128'({bresp, rresp, rdata}), 128'(0));
        check("rst_reg_out", reg_out, 128'(0));
        rst_n = 1;
        @(negedge clk);
        check("post_rst_readys", 128'({awready, wready, arready}), 128'(3'b111));

        // Table-driven write/read-back
        for (int i = 0; i < 10; i++) begin
            axi_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, 0, br);
            model_write(vecs[i].addr, vecs[i].data, vecs[i].strb);
            check($sformatf("vec%0d_bresp", i), 128'(br), 128'(vecs[i].exp_resp));
            axi_read(vecs[i].addr, 0, rd, rr);
            check($sformatf("vec%0d_rdata", i), 128'(rd), 128'(vecs[i].exp_rd));
            check($sformatf("vec%0d_rresp", i), 128'(rr), 128'(vecs[i].exp_resp));
            if (i == 3)
                check("reg_out_1234", reg_out, 128'h00000004_00000003_00000002_00000001);
        end
        check("reg_out_table_end", reg_out, 128'h00000004_00000003_11BB33DD_7F000001);

        // W three cycles ahead of AW
        wvalid = 1; wdata = 32'h55; wstrb = 4'hF;
        check("A_wready_idle", 128'(wready), 128'(1));
        @(negedge clk); wvalid = 0;
        check("A_wready_drop", 128'(wready), 128'(0));
        check("A_awready_held", 128'(awready), 128'(1));
        check("A_no_bvalid", 128'(bvalid), 128'(0));
        @(negedge clk); @(negedge clk);
        awvalid = 1; awaddr = 5'h08;
        @(negedge clk); awvalid = 0;
        check("A_bvalid_next", 128'(bvalid), 128'(1));
        check("A_bresp", 128'(bresp), 128'(0));
        bready = 1; @(negedge clk); bready = 0;
        check("A_bvalid_clear", 128'(bvalid), 128'(0));
        model_write(5'h08, 32'h55, 4'hF);
        axi_read(5'h08, 0, rd, rr);
        check("A_readback", 128'(rd), 128'(32'h55));

        // BREADY held low; second AW must wait
        awvalid = 1; wvalid = 1; awaddr = 5'h04; wdata = 32'h66; wstrb = 4'hF;
        @(negedge clk);
        wvalid = 0; awaddr = 5'h0C;
        for (int c = 0; c < 5; c++) begin
            check($sformatf("B_hold%0d", c), 128'({bvalid, awready, wready}), 128'(3'b100));
            @(negedge clk);
        end
        bready = 1; @(negedge clk); bready = 0;
        check("B_after_bready", 128'({bvalid, awready, wready}), 128'(3'b011));
        @(negedge clk); awvalid = 0;
        check("B_aw2_taken", 128'({awready, wready}), 128'(2'b01));
        wvalid = 1; wdata = 32'h77;
        @(negedge clk); wvalid = 0;
        check("B_bvalid2", 128'(bvalid), 128'(1));
        bready = 1; @(negedge clk); bready = 0;
        model_write(5'h04, 32'h66, 4'hF);
        model_write(5'h0C, 32'h77, 4'hF);
        check("B_reg_out", reg_out, model_regout());

        // Read and write commit to reg 0 on the same edge
        axi_write(5'h00, 32'h1, 4'hF, 0, 0, br);
        model_write(5'h00, 32'h1, 4'hF);
        awvalid = 1; wvalid = 1; awaddr = 5'h00; wdata = 32'h9; wstrb = 4'hF;
        arvalid = 1; araddr = 5'h00;
        check("C_all_ready", 128'({awready, wready, arready}), 128'(3'b111));
        @(negedge clk);
        awvalid = 0; wvalid = 0; arvalid = 0;
        check("C_rvalid_arready", 128'({rvalid, arready, bvalid}), 128'(3'b101));
        check("C_old_value", 128'(rdata), 128'(32'h1));
        @(negedge clk);
        check("C_rdata_stable", 128'({rvalid, rdata}), 128'({1'b1, 32'h1}));
        bready = 1; rready = 1;
        @(negedge clk); bready = 0; rready = 0;
        check("C_ar_reassert", 128'({rvalid, arready}), 128'(2'b01));
        model_write(5'h00, 32'h9, 4'hF);
        axi_read(5'h00, 0, rd, rr);
        check("C_new_value", 128'(rd), 128'(32'h9));

        // Reset asserted while holding a write address
        awvalid = 1; awaddr = 5'h04;
        @(negedge clk); awvalid = 0;
        check("D_in_have_aw", 128'({awready, wready}), 128'(2'b01));
        rst_n = 0;
        #1;
        check("D_rst_outputs", 128'({awready, wready, arready, bvalid, rvalid, bresp, rresp}), 128'(0));
        check("D_rst_rdata", 128'(rdata), 128'(0));
        check("D_rst_reg_out", reg_out, 128'(0));
        model_reset();
        @(negedge clk); rst_n = 1;
        @(negedge clk);
        axi_write(5'h0C, 32'h1234_5678, 4'hF, 0, 0, br);
        model_write(5'h0C, 32'h1234_5678, 4'hF);
        check("D_bresp", 128'(br), 128'(0));
        axi_read(5'h0C, 1, rd, rr);
        check("D_readback", 128'(rd), 128'(32'h1234_5678));
        axi_read(5'h04, 0, rd, rr);
        check("D_no_partial", 128'(rd), 128'(0));

        // Randomised traffic against the model
        for (int n = 0; n < 80; n++) begin
            ra   = AW'($urandom_range(0, 7) * 4);
            rdat = $urandom;
            rs   = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                axi_write(ra, rdat, rs, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), br);
                model_write(ra, rdat, rs);
                check($sformatf("rnd%0d_bresp", n), 128'(br), 128'(model_resp(ra)));
            end else begin
                axi_read(ra, int'($urandom_range(0, 2)), rd, rr);
                check($sformatf("rnd%0d_rdata", n), 128'(rd), 128'(model_rdata(ra)));
                check($sformatf("rnd%0d_rresp", n), 128'(rr), 128'(model_resp(ra)));
            end
            check($sformatf("rnd%0d_reg_out", n), reg_out, model_regout());
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
